mmio_store_bridge: RTL and testbench

- Sits between the CPU data-memory port and the data RAM and MMIO peripherals, including the LED register block.
- Splits each CPU store by address region:
  - DRAM stores pass straight through as a gated write-enable.
  - MMIO stores are queued in a small FIFO and issued one per handshake on a valid/ready MMIO write channel.
- Stalls the CPU when the queue is full and flags stores to unmapped MMIO pages.

---
 rtl/mmio_store_bridge_if.sv | 11 +
 rtl/mmio_store_bridge.sv | 84 ++++++++
 tb/tb_mmio_store_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_store_bridge_if.sv
// MMIO write channel: valid/ready handshake carrying one {addr, wdata} store per transfer.
// The bridge drives the request side (master); a peripheral accepts it (slave).
interface mmio_store_bridge_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;

  modport master (output valid, output addr, output wdata, input ready);
  modport slave  (input valid, input addr, input wdata, output ready);
endinterface

// File: rtl/mmio_store_bridge.sv
// Splits CPU stores by region: DRAM stores become a same-cycle write enable, while
// MMIO stores queue in a small FIFO and drain one per handshake on the MMIO write channel.
module mmio_store_bridge #(
  parameter int          DEPTH = 4,        // power of 2, >= 2
  parameter logic [15:0] PAGE0 = 16'h8000, // red LED page
  parameter logic [15:0] PAGE1 = 16'h8004  // green LED page
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   we,
  input  logic [31:0]            daddr,
  input  logic [31:0]            din,
  output logic                   we_dram,
  output logic                   cpu_stall,
  mmio_store_bridge_if.master    mmio,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   unmapped_err,
  output logic [31:0]            err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic is_mmio, mapped, full, enq, deq, unmapped;

  assign is_mmio  = daddr[31];
  assign mapped   = (daddr[31:16] == PAGE0) || (daddr[31:16] == PAGE1);
  assign full     = (count == CW'(DEPTH));
  assign unmapped = we & is_mmio & ~mapped;

  // Stall looks only at the registered count, so a dequeue in the same cycle
  // does not release it; the CPU simply retries next cycle.
  assign enq       = we & is_mmio & mapped & ~full;
  assign cpu_stall = we & is_mmio & mapped & full;
  assign we_dram   = we & ~is_mmio;

  // First-word-fall-through: the head entry is presented directly from storage.
  assign mmio.valid = (count != '0);
  assign mmio.addr  = mem[rd_ptr].addr;
  assign mmio.wdata = mem[rd_ptr].data;
  assign deq        = mmio.valid & mmio.ready;
  assign pending    = count;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values, independent of the order the always_ff blocks run in.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      unmapped_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      // Only the first offending address is kept until reset.
      if (unmapped && !unmapped_err) begin
        unmapped_err <= 1'b1;
        err_addr     <= daddr;
      end
    end
  end

  // NOTE: storage has no reset; count gates validity, so stale contents are never
  // observed and the array can map onto plain RAM/register cells without a reset net.
  always_ff @(posedge sys_clk) begin
    if (enq) mem[wr_ptr] <= '{addr: daddr, data: din};
  end

endmodule

// File: tb/tb_mmio_store_bridge.sv
// Directed bench for mmio_store_bridge: DRAM pass-through, MMIO queueing, stall,
// wrap-around ordering, unmapped-page capture and reset mid-drain.
module tb_mmio_store_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        we;
  logic [31:0] daddr, din;
  logic        we_dram, cpu_stall, unmapped_err;
  logic [2:0]  pending;
  logic [31:0] err_addr;

  mmio_store_bridge_if mmio ();

  mmio_store_bridge #(.DEPTH(4), .PAGE0(16'h8000), .PAGE1(16'h8004)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .we           (we),
    .daddr        (daddr),
    .din          (din),
    .we_dram      (we_dram),
    .cpu_stall    (cpu_stall),
    .mmio         (mmio.master),
    .pending      (pending),
    .unmapped_err (unmapped_err),
    .err_addr     (err_addr)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int max_pend = 0;
  logic [63:0] issued [$];

  // Records every completed handshake ({addr, wdata}) with pre-edge values.
  always @(posedge sys_clk) begin
    if (!sys_rst && mmio.valid && mmio.ready) issued.push_back({mmio.addr, mmio.wdata});
    if (int'(pending) > max_pend) max_pend = int'(pending);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (pending != 3'd0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_to_empty", 32'(pending), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr [10];
    logic [31:0] exp_data [10];
    int guard;

    sys_rst    = 1'b1;
    we         = 1'b0;
    daddr      = '0;
    din        = '0;
    mmio.ready = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
    #1;
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_valid", 32'(mmio.valid), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_err", 32'(unmapped_err), 32'd0);
    check("rst_err_addr", err_addr, 32'h0);

    // 1: DRAM store
    we = 1'b1; daddr = 32'h0000_0100; din = 32'h1234;
    #1;
    check("dram_we", 32'(we_dram), 32'd1);
    check("dram_stall", 32'(cpu_stall), 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("dram_we_off", 32'(we_dram), 32'd0);
    check("dram_valid", 32'(mmio.valid), 32'd0);
    check("dram_pending", 32'(pending), 32'd0);

    // 2: single MMIO store, ready held high
    mmio.ready = 1'b1;
    we = 1'b1; daddr = 32'h8000_0000; din = 32'h0100_0000;
    #1;
    check("mmio_no_dram", 32'(we_dram), 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("single_valid", 32'(mmio.valid), 32'd1);
    check("single_addr", mmio.addr, 32'h8000_0000);
    check("single_wdata", mmio.wdata, 32'h0100_0000);
    tick();
    check("single_valid_off", 32'(mmio.valid), 32'd0);
    check("single_pending", 32'(pending), 32'd0);
    check("single_issued_n", 32'(issued.size()), 32'd1);
    if (issued.size() > 0) check("single_issued", issued[0][31:0], 32'h0100_0000);
    issued.delete();

    // 3: fill and stall with ready low
    mmio.ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      we = 1'b1; daddr = 32'h8004_0000; din = 32'(i);
      #1;
      check($sformatf("fill_stall_%0d", i), 32'(cpu_stall), (i == 5) ? 32'd1 : 32'd0);
      tick();
    end
    check("full_pending", 32'(pending), 32'd4);
    check("full_stall_held", 32'(cpu_stall), 32'd1);
    mmio.ready = 1'b1;
    #1;
    check("stall_same_cycle_deq", 32'(cpu_stall), 32'd1);
    tick();
    check("retry_stall", 32'(cpu_stall), 32'd0);
    check("retry_pending", 32'(pending), 32'd3);
    tick();
    we = 1'b0;
    #1;
    check("retry_accepted_pending", 32'(pending), 32'd3);
    wait_empty(20);
    check("fill_issued_n", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5 && i < issued.size(); i++)
      check($sformatf("fill_order_%0d", i), issued[i][31:0], 32'(i + 1));
    issued.delete();

    // 4: wrap-around, alternating pages, ready toggling every cycle
    max_pend   = 0;
    mmio.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_addr[i] = {(i % 2 == 0) ? 16'h8000 : 16'h8004, 16'(i * 4)};
      exp_data[i] = 32'hA000_0000 + 32'(i);
    end
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; daddr = exp_addr[i]; din = exp_data[i];
      #1;
      guard = 0;
      while (cpu_stall && guard < 10) begin
        tick();
        mmio.ready = ~mmio.ready;
        #1;
        guard++;
      end
      tick();
      mmio.ready = ~mmio.ready;
    end
    we = 1'b0;
    mmio.ready = 1'b1;
    wait_empty(20);
    check("wrap_max_pending_le4", 32'(max_pend <= 4), 32'd1);
    check("wrap_issued_n", 32'(issued.size()), 32'd10);
    for (int i = 0; i < 10 && i < issued.size(); i++) begin
      check($sformatf("wrap_addr_%0d", i), issued[i][63:32], exp_addr[i]);
      check($sformatf("wrap_data_%0d", i), issued[i][31:0], exp_data[i]);
    end
    issued.delete();

    // 5: unmapped stores; only the first address is captured
    we = 1'b1; daddr = 32'h8010_0000; din = 32'h55;
    #1;
    check("unmapped_stall", 32'(cpu_stall), 32'd0);
    check("unmapped_no_dram", 32'(we_dram), 32'd0);
    tick();
    daddr = 32'h8020_0000;
    #1;
    check("unmapped2_stall", 32'(cpu_stall), 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("unmapped_err", 32'(unmapped_err), 32'd1);
    check("unmapped_err_addr", err_addr, 32'h8010_0000);
    check("unmapped_pending", 32'(pending), 32'd0);
    check("unmapped_valid", 32'(mmio.valid), 32'd0);

    // 6: reset mid-drain discards queued entries
    mmio.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; daddr = 32'h8000_0000; din = 32'hB0 + 32'(i);
      tick();
    end
    we = 1'b0;
    #1;
    check("pre_rst_pending", 32'(pending), 32'd3);
    check("pre_rst_valid", 32'(mmio.valid), 32'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    #1;
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_valid", 32'(mmio.valid), 32'd0);
    check("midrst_err", 32'(unmapped_err), 32'd0);
    check("midrst_err_addr", err_addr, 32'h0);
    issued.delete();
    mmio.ready = 1'b1;
    we = 1'b1; daddr = 32'h8000_0000; din = 32'h0000_00DD;
    tick();
    we = 1'b0;
    #1;
    check("post_rst_valid", 32'(mmio.valid), 32'd1);
    check("post_rst_addr", mmio.addr, 32'h8000_0000);
    check("post_rst_wdata", mmio.wdata, 32'h0000_00DD);
    tick();
    check("post_rst_pending", 32'(pending), 32'd0);
    check("post_rst_issued_n", 32'(issued.size()), 32'd1);
    if (issued.size() > 0) check("post_rst_issued", issued[0][31:0], 32'h0000_00DD);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
